// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT input buffer: size defaults, FSM states, address bit reversal.
// Pure package, no logic; bit_reverse handles widths up to ADDR_WIDTH_MAX.
package fft_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 12;
    localparam int ADDR_WIDTH_MAX = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // Reverses the low 'width' bits of 'a'; bits at and above 'width' return as zero.
    function automatic logic [ADDR_WIDTH_MAX-1:0] bit_reverse(
        input logic [ADDR_WIDTH_MAX-1:0] a,
        input int                        width
    );
        logic [ADDR_WIDTH_MAX-1:0] r;
        logic [ADDR_WIDTH_MAX-1:0] t;
        r = '0;
        t = a;
        for (int i = 0; i < ADDR_WIDTH_MAX; i++) begin
            if (i < width) begin
                r = {r[ADDR_WIDTH_MAX-2:0], t[0]};
                t = t >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_input_buffer_sample_ram.sv
// Simple dual-port sample store: one write port, registered read port with enable.
// Read latency 1 cycle; rd_data holds its value while rd_en is low (no backpressure of its own).
module sample_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // Array deliberately has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fft_input_buffer.sv
// Frame buffer feeding an FFT: load by address in IDLE, then stream N samples in natural or bit-reversed order.
// Start-to-first-beat 2 cycles, one beat/cycle; out_valid/ready backpressure freezes the output beat and the read pointer.
module fft_input_buffer
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_drop,
    input  logic                  start,
    input  logic                  bit_rev,
    output logic                  busy,
    output logic                  done,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  out_last
);

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH:0]   k;
    logic                  bit_rev_q;
    logic                  issue;
    logic                  accept;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] k_addr;
    logic [ADDR_WIDTH-1:0] k_rev;
    logic [ADDR_WIDTH-1:0] rd_addr;

    assign accept  = out_valid && out_ready;
    assign k_addr  = k[ADDR_WIDTH-1:0];
    assign k_rev   = ADDR_WIDTH'(bit_reverse(ADDR_WIDTH_MAX'(k_addr), ADDR_WIDTH));
    assign rd_addr = bit_rev_q ? k_rev : k_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // k has one extra bit so that k == N (frame fully issued) is just its MSB.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        ram_we    = 1'b0;
        issue     = 1'b0;
        case (state)
            S_IDLE: begin
                ram_we = wr_en;
                if (start) begin
                    state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                busy  = 1'b1;
                issue = !k[ADDR_WIDTH] && (!out_valid || out_ready);
                if (accept && out_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k         <= '0;
            bit_rev_q <= 1'b0;
        end else if (state == S_IDLE && start) begin
            k         <= '0;
            bit_rev_q <= bit_rev;
        end else if (issue) begin
            k         <= k + 1'b1;
        end
    end

    // Sideband registers track the read in flight, so they line up with the RAM's registered data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else if (issue) begin
            out_valid <= 1'b1;
            out_index <= k_addr;
            out_last  <= &k_addr;
        end else if (accept) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= wr_en && (state != S_IDLE);
        end
    end

    sample_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sample_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (ram_we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (issue),
        .rd_addr (rd_addr),
        .rd_data (out_data)
    );

endmodule

// File: tb/tb_fft_input_buffer.sv
// Directed bench for fft_input_buffer with N=8: scoreboard of expected beats, checked as the DUT emits them.
module tb_fft_input_buffer;

    localparam int DW = 32;
    localparam int AW = 3;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_drop;
    logic          start;
    logic          bit_rev;
    logic          busy;
    logic          done;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_index;
    logic          out_last;

    fft_input_buffer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_drop   (wr_drop),
        .start     (start),
        .bit_rev   (bit_rev),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] idx;
        logic          last;
        int            off;
    } beat_t;

    beat_t         sb[$];
    beat_t         e;
    logic [DW-1:0] mem_m [0:7];
    int            pass_cnt = 0;
    int            fail_cnt = 0;
    int            cyc = 0;
    int            start_cyc = 0;
    int            beat_cnt = 0;
    logic          held = 1'b0;
    logic [DW-1:0] held_data;
    logic [AW-1:0] held_idx;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: stalled beats must hold still; accepted beats are matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (held) begin
                check("hold_data", 64'(out_data), 64'(held_data));
                check("hold_index", 64'(out_index), 64'(held_idx));
            end
            if (out_ready) begin
                held = 1'b0;
                if (sb.size() == 0) begin
                    check("unexpected_beat", 64'(sb.size()), 64'(1));
                end else begin
                    e = sb.pop_front();
                    check("beat_data", 64'(out_data), 64'(e.data));
                    check("beat_index", 64'(out_index), 64'(e.idx));
                    check("beat_last", 64'(out_last), 64'(e.last));
                    check("beat_cycle", 64'(cyc - start_cyc), 64'(e.off));
                    beat_cnt++;
                end
            end else begin
                held      = 1'b1;
                held_data = out_data;
                held_idx  = out_index;
            end
        end else begin
            held = 1'b0;
        end
    end

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        mem_m[a] = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_data"}, 64'(out_data), 64'(0));
        check({tag, "_index"}, 64'(out_index), 64'(0));
        check({tag, "_last"}, 64'(out_last), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_drop"}, 64'(wr_drop), 64'(0));
    endtask

    // Called at posedge+1 with the DUT idle; the start cycle is offset 0.
    task automatic run_frame(input logic br, input logic stall, input int drop_at,
                             input int start_at, input int abort_at, input logic wr_with_start);
        int            exp_done;
        int            done_cnt;
        int            done_off;
        logic [AW-1:0] kb;
        logic [AW-1:0] a;
        beat_t         b;
        exp_done = stall ? 13 : 10;
        done_cnt = 0;
        done_off = -1;
        beat_cnt = 0;
        if (wr_with_start) begin
            wr_en    = 1'b1;
            wr_addr  = 3'd0;
            wr_data  = 32'h4000_0000;
            mem_m[0] = 32'h4000_0000;
        end
        for (int k = 0; k < 8; k++) begin
            kb     = 3'(k);
            a      = br ? {kb[0], kb[1], kb[2]} : kb;
            b.data = mem_m[a];
            b.idx  = kb;
            b.last = (k == 7);
            b.off  = k + 2 + ((stall && k >= 2) ? 3 : 0);
            sb.push_back(b);
        end
        bit_rev   = br;
        start     = 1'b1;
        start_cyc = cyc;
        for (int off = 1; off <= exp_done + 3; off++) begin
            @(posedge clk);
            #1;
            start     = 1'b0;
            wr_en     = 1'b0;
            out_ready = 1'b1;
            if (done) begin
                done_cnt++;
                if (done_off < 0) done_off = off;
            end
            if (off == 1) check("busy_stream", 64'(busy), 64'(1));
            if (off == 1 && wr_with_start) check("start_write_no_drop", 64'(wr_drop), 64'(0));
            if (off == exp_done + 1) check("busy_idle", 64'(busy), 64'(0));
            if (stall && off >= 4 && off <= 6) out_ready = 1'b0;
            if (off == drop_at) begin
                wr_en   = 1'b1;
                wr_addr = 3'd5;
                wr_data = 32'hDEAD_BEEF;
            end
            if (drop_at > 0 && off == drop_at + 1) check("wr_drop_pulse", 64'(wr_drop), 64'(1));
            if (drop_at > 0 && off == drop_at + 2) check("wr_drop_clear", 64'(wr_drop), 64'(0));
            if (off == start_at) start = 1'b1;
            if (off == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_all_zero("abort");
                check("abort_no_done", 64'(done_cnt), 64'(0));
                check("abort_beats", 64'(beat_cnt), 64'(4));
                sb.delete();
                @(posedge clk);
                #3;
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                return;
            end
        end
        check("done_cycle", 64'(done_off), 64'(exp_done));
        check("done_count", 64'(done_cnt), 64'(1));
        check("beat_count", 64'(beat_cnt), 64'(8));
        check("sb_empty", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        start     = 1'b0;
        bit_rev   = 1'b0;
        out_ready = 1'b1;
        #12;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) write_word(3'(i), 32'h3F80_0000 + 32'(i));
        check("load_no_drop", 64'(wr_drop), 64'(0));

        run_frame(1'b0, 1'b0, 0, 0, 0, 1'b0);   // natural order, full throughput
        run_frame(1'b1, 1'b0, 0, 0, 0, 1'b0);   // bit-reversed order
        run_frame(1'b0, 1'b1, 0, 0, 0, 1'b0);   // 3-cycle stall on beat 2
        run_frame(1'b0, 1'b0, 3, 0, 0, 1'b0);   // write while busy is dropped
        run_frame(1'b0, 1'b0, 0, 0, 0, 1'b0);   // data at k=5 unchanged
        run_frame(1'b0, 1'b0, 0, 0, 6, 1'b0);   // reset after beat 3
        run_frame(1'b0, 1'b0, 0, 0, 0, 1'b0);   // replay after reset
        run_frame(1'b0, 1'b0, 0, 6, 0, 1'b0);   // start at beat 4 ignored
        run_frame(1'b1, 1'b0, 0, 0, 0, 1'b1);   // write and start together

        $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
        $finish;
    end

endmodule

// File: doc/fft_input_buffer.md
FFT_INPUT_BUFFER -- requirements
Module: fft_input_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sample word width (IEEE-754 single precision by default).
REQ-002 Parameter ADDR_WIDTH, default 12; depth and frame length N = 2**ADDR_WIDTH.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 wr_en  input  1  write strobe for the load port.
REQ-006 wr_addr  input  ADDR_WIDTH  write address.
REQ-007 wr_data  input  DATA_WIDTH  write data.
REQ-008 wr_drop  output  1  one-cycle pulse: a write was rejected.
REQ-009 start  input  1  begin streaming one frame.
REQ-010 bit_rev  input  1  read order, sampled with start: 0 natural, 1 bit-reversed.
REQ-011 busy  output  1  high while a frame is streaming.
REQ-012 done  output  1  one-cycle pulse after the last beat is accepted.
REQ-013 out_valid  output  1  out_data/out_index/out_last valid.
REQ-014 out_ready  input  1  downstream accepts the beat.
REQ-015 out_data  output  DATA_WIDTH  sample.
REQ-016 out_index  output  ADDR_WIDTH  sequence position k, 0..N-1.
REQ-017 out_last  output  1  high on beat k = N-1.

Function
REQ-018 The FSM SHALL have states IDLE, STREAM and DONE.
REQ-019 IDLE: wr_en writes wr_data to wr_addr at the clock edge; start=1 latches bit_rev and clears counter k to 0; next state STREAM.
REQ-020 In STREAM, a read SHALL be issued when k < N and (!out_valid or out_ready); read address = k if natural order, else k with its ADDR_WIDTH bits reversed; k increments on issue.
REQ-021 Memory read latency SHALL be 1 cycle: out_valid rises the cycle after issue; out_index = issued k; out_last = (k == N-1).
REQ-022 When out_valid=1 and out_ready=0, out_data, out_index and out_last SHALL hold stable and no read SHALL be issued.
REQ-023 A beat SHALL be consumed when out_valid && out_ready; out_valid falls if no read is issued in the same cycle.
REQ-024 Full throughput with out_ready held high: one beat per cycle; start at cycle 0 gives first out_valid at cycle 2 and out_last at cycle N+1.
REQ-025 Acceptance of the out_last beat SHALL move the FSM to DONE; DONE asserts done for one cycle, then IDLE.
REQ-026 busy SHALL be 1 in STREAM and DONE, 0 in IDLE.
REQ-027 wr_en in STREAM or DONE SHALL NOT modify memory and SHALL pulse wr_drop the next cycle.
REQ-028 start outside IDLE SHALL be ignored; simultaneous start and wr_en in IDLE SHALL perform the write and start the frame.
REQ-029 Memory contents SHALL persist across frames; the same frame may be streamed repeatedly.

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE with k=0 and out_valid=0, out_last=0, busy=0, done=0, wr_drop=0, out_index=0, out_data=0.
REQ-031 Reset mid-frame SHALL abort streaming with no done pulse; memory contents are not cleared and are undefined only after power-up.

Structure
REQ-032 Shared package fft_pkg SHALL hold DATA_WIDTH/ADDR_WIDTH defaults, the state enumeration and a bit-reverse function.
REQ-033 Storage SHALL be one sub-module, sample_ram: simple dual-port, one write port, synchronous read port with read enable, no reset on the array.

Verification (ADDR_WIDTH=3, N=8)
REQ-034 Write mem[i]=0x3F800000+i for i=0..7, start with bit_rev=0, out_ready=1 -> out_data 0x3F800000..0x3F800007 on cycles 2..9, out_last on cycle 9, done on cycle 10.
REQ-035 Same load, bit_rev=1 -> out_data suffixes 0,4,2,6,1,5,3,7; out_index 0..7.
REQ-036 bit_rev=0, out_ready low for 3 cycles at beat k=2 -> beat 2 held stable 3 cycles; no beat lost or duplicated; done 3 cycles later than in REQ-034.
REQ-037 wr_en to addr 5 with 0xDEADBEEF while busy -> wr_drop pulses; next frame still outputs 0x3F800005 at k=5.
REQ-038 rst_n low after beat 3 -> all outputs 0 immediately, no done; a new start replays the frame from k=0 with unchanged data.
REQ-039 start pulsed at beat 4 of a frame -> ignored; exactly 8 beats and one done.
